// File: rtl/interleaver_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : interleaver_sequencer                                           |
// | Brief    : Counted load / capture / index-drain control for the interleaver|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module interleaver_sequencer #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144,
    parameter int CNT_W   = 13
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             k_size,
    input  logic             ready,
    output logic             in_ready,
    output logic             shift_en,
    output logic             k_latched,
    output logic             capture,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_index,
    output logic             busy,
    output logic             block_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LOAD    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DRAIN   = 2'd3;

    localparam logic [CNT_W-1:0] c_small_last = CNT_W'(K_SMALL - 1);
    localparam logic [CNT_W-1:0] c_large_last = CNT_W'(K_LARGE - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_in_cnt;
    logic [CNT_W-1:0] r_out_index;
    logic             r_k_latched;
    logic             r_block_done;
    logic [CNT_W-1:0] w_last_latched;
    logic [CNT_W-1:0] w_last_new;
    logic             w_handshake;
    logic             w_final_hs;

    // Block length for the block in flight vs. the one about to start.
    assign w_last_latched = r_k_latched ? c_large_last : c_small_last;
    assign w_last_new     = k_size ? c_large_last : c_small_last;

    assign w_handshake = (r_state == S_DRAIN) & out_ready;
    assign w_final_hs  = w_handshake & (r_out_index == w_last_latched);

    assign shift_en   = ready & in_ready;
    assign k_latched  = r_k_latched;
    assign out_index  = r_out_index;
    assign block_done = r_block_done;

    always_ff @(posedge clk) begin
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (shift_en) begin
                    w_next_state = (w_last_new == '0) ? S_CAPTURE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (shift_en && (r_in_cnt == w_last_latched)) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: w_next_state = S_DRAIN;
            S_DRAIN: begin
                if (w_final_hs) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        capture   = 1'b0;
        out_valid = 1'b0;
        busy      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:    in_ready  = ~clear;
            S_LOAD:    in_ready  = ~clear;
            S_CAPTURE: capture   = 1'b1;
            S_DRAIN:   out_valid = 1'b1;
            default:   in_ready  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_in_cnt     <= '0;
            r_out_index  <= '0;
            r_k_latched  <= 1'b0;
            r_block_done <= 1'b0;
        end else begin
            r_block_done <= w_final_hs;
            if ((r_state == S_IDLE) && shift_en) begin
                r_k_latched <= k_size;
                r_in_cnt    <= CNT_W'(1);
            end else if ((r_state == S_LOAD) && shift_en) begin
                r_in_cnt <= r_in_cnt + CNT_W'(1);
            end else if (r_state == S_CAPTURE) begin
                r_in_cnt <= '0;
            end
            if (w_final_hs) begin
                r_out_index <= '0;
            end else if (w_handshake) begin
                r_out_index <= r_out_index + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_interleaver_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_interleaver_sequencer                                        |
// | Brief    : Segment-based bench; expectations derived from block timeline   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_interleaver_sequencer;

    localparam int CNT_W = 13;
    localparam int MAXN  = 16384;

    logic             clk = 1'b0;
    logic             clear = 1'b1;
    logic             k_size = 1'b0;
    logic             ready = 1'b0;
    logic             in_ready;
    logic             shift_en;
    logic             k_latched;
    logic             capture;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CNT_W-1:0] out_index;
    logic             busy;
    logic             block_done;

    interleaver_sequencer #(.K_SMALL(1056), .K_LARGE(6144), .CNT_W(CNT_W)) dut (
        .clk(clk), .clear(clear), .k_size(k_size), .ready(ready),
        .in_ready(in_ready), .shift_en(shift_en), .k_latched(k_latched),
        .capture(capture), .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .busy(busy), .block_done(block_done)
    );

    always #5 clk = ~clk;

    bit rdy[MAXN], ordy[MAXN], ks[MAXN];
    bit e_shift[MAXN], e_cap[MAXN], e_valid[MAXN], e_done[MAXN], e_busy[MAXN], e_kl[MAXN];
    int e_idx[MAXN];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
        end
    endtask

    // Lay out the expected timeline: wait for a ready bit, accept K ready
    // cycles, one capture cycle, then K out_ready handshakes, done pulse.
    task automatic build_model(input int n);
        int t, acc, hs, k;
        bit kl_cur;
        for (int i = 0; i < n; i++) begin
            e_shift[i] = 0; e_cap[i] = 0; e_valid[i] = 0; e_done[i] = 0;
            e_busy[i] = 0; e_kl[i] = 0; e_idx[i] = 0;
        end
        kl_cur = 0;
        t = 0;
        while (t < n) begin
            if (!rdy[t]) begin
                e_kl[t] = kl_cur;
                t++;
                continue;
            end
            e_kl[t] = kl_cur;
            e_shift[t] = 1;
            kl_cur = ks[t];
            k = kl_cur ? 6144 : 1056;
            acc = 1;
            t++;
            while (t < n && acc < k) begin
                e_busy[t] = 1; e_kl[t] = kl_cur; e_shift[t] = rdy[t];
                acc += int'(rdy[t]);
                t++;
            end
            if (t >= n) break;
            e_busy[t] = 1; e_kl[t] = kl_cur; e_cap[t] = 1;
            t++;
            hs = 0;
            while (t < n && hs < k) begin
                e_busy[t] = 1; e_kl[t] = kl_cur; e_valid[t] = 1; e_idx[t] = hs;
                hs += int'(ordy[t]);
                t++;
            end
            if (t >= n) break;
            e_done[t] = 1;
        end
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_segment(input int n);
        clear = 1'b1; ready = 1'b1; out_ready = 1'b1; k_size = 1'($urandom);
        @(negedge clk);
        check("clear_shift_en", shift_en, 0);
        check("clear_in_ready", in_ready, 0);
        @(posedge clk); #1;
        build_model(n);
        clear = 1'b0;
        for (int t = 0; t < n; t++) begin
            cyc = t;
            ready = rdy[t]; out_ready = ordy[t]; k_size = ks[t];
            @(negedge clk);
            check("shift_en", shift_en, e_shift[t]);
            check("in_ready", in_ready, (e_cap[t] | e_valid[t]) ? 0 : 1);
            check("capture", capture, e_cap[t]);
            check("out_valid", out_valid, e_valid[t]);
            check("out_index", out_index, e_idx[t]);
            check("block_done", block_done, e_done[t]);
            check("busy", busy, e_busy[t]);
            check("k_latched", k_latched, e_kl[t]);
            @(posedge clk); #1;
        end
    endtask

    task automatic fill(input bit r, input bit o, input bit k, input int n);
        for (int i = 0; i < n; i++) begin
            rdy[i] = r; ordy[i] = o; ks[i] = k;
        end
    endtask

    initial begin
        @(posedge clk); #1;

        // Small block, free-flowing
        fill(1, 1, 0, 2118);
        run_segment(2118);

        // Large block, k_size toggling after bit 0
        fill(1, 1, 0, 12290);
        for (int i = 0; i < 12290; i++) ks[i] = (i % 2 == 0);
        run_segment(12290);

        // ready pattern 1,0,0,1 during load, held high afterwards
        fill(1, 1, 0, 3300);
        for (int i = 0; i < 2200; i++) rdy[i] = ((i % 4) == 0) || ((i % 4) == 3);
        run_segment(3300);

        // out_ready stall of 3 cycles at index 500
        fill(1, 1, 0, 2120);
        for (int i = 1557; i <= 1559; i++) ordy[i] = 0;
        run_segment(2120);

        // Abort in LOAD at in_cnt=700, abort in DRAIN at out_index=20, then full block
        fill(1, 1, 0, 700);
        run_segment(700);
        fill(1, 1, 0, 1077);
        run_segment(1077);
        fill(1, 1, 0, 2118);
        run_segment(2118);

        // Back-to-back small then large block
        fill(1, 1, 0, 14402);
        for (int i = 2113; i < 14402; i++) ks[i] = 1;
        run_segment(14402);

        // Random traffic
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 4000; i++) begin
                rdy[i]  = ($urandom_range(0, 3) != 0);
                ordy[i] = ($urandom_range(0, 3) != 0);
                ks[i]   = ($urandom_range(0, 7) == 0);
            end
            run_segment(4000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
